// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults and entry type for the instruction fetch stage
// Purpose: default widths, reset PC, the queue entry type and a sizing helper.
// Ports: none (package).
package fetch_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_INSTR_W = 16;
  localparam int unsigned DEF_RESET_PC = 0;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Bits needed to hold an occupancy value of 0..depth inclusive.
  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular prefetch FIFO with push/pop/flush and registered head
// Purpose: holds fetched {instr, pc} entries between the ROM return and decode.
// Ports:
//   CLOCK_50  in   clock
//   reset     in   async active-low reset
//   flush     in   drop all entries (wins over push/pop)
//   push      in   write pushData at the tail
//   pushData  in   entry to write
//   pop       in   retire the head entry (ignored when empty)
//   headData  out  entry at the head, driven from registered state only
//   headValid out  queue is not empty
//   count     out  number of stored entries
module fetch_queue import fetch_pkg::*; #(
  parameter type T = fetch_entry_t,
  parameter int QDEPTH = 2,
  localparam int PTR_W = $clog2(QDEPTH),
  localparam int CNT_W = cntWidth(QDEPTH)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  T                 pushData,
  input  logic             pop,
  output T                 headData,
  output logic             headValid,
  output logic [CNT_W-1:0] count
);

  T           mem [QDEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic       doPop;
  logic       full;

  assign doPop     = pop && (count != '0);
  assign full      = (count == CNT_W'(QDEPTH));
  assign headValid = (count != '0);
  assign headData  = mem[headPtr];

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      // The issue logic upstream reserves a slot for every fetch, so a
      // push into a full queue without a simultaneous pop means that
      // reservation has broken.
      assert (!(push && !doPop && full));
      if (push) begin
        mem[tailPtr] <= pushData;
        tailPtr      <= tailPtr + 1'b1;
      end
      if (doPop) headPtr <= headPtr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(doPop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, ROM issue and prefetch buffering for decode
// Purpose: fetches sequential instructions from a 1-cycle-latency ROM into a
// small queue and hands them to decode with a valid/ready handshake.
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_stall counters.
// Ports:
//   CLOCK_50     in   clock
//   reset        in   async active-low reset
//   mem_addr     out  ROM address (equals fetch_pc)
//   mem_q        in   ROM data for the address sampled on the previous edge
//   instr        out  instruction at queue head
//   instr_pc     out  PC of instr
//   instr_valid  out  head holds a valid instruction
//   instr_ready  in   decode accepts the head this cycle
//   redirect     in   restart fetching at redirect_pc
//   redirect_pc  in   redirect target
//   fetch_pc     out  next address to be requested
//   perf_fetched out  saturating pop count (FETCH_PERF_EN only)
//   perf_stall   out  saturating valid-but-not-ready count (FETCH_PERF_EN only)
module instr_fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int QDEPTH = 2,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_q,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  fetch_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CNT_W = cntWidth(QDEPTH);
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] inflightPc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [OCC_W-1:0]  occupancy;
  logic              pop;
  logic              issue;
  logic              push;
  entry_t            pushEntry;
  entry_t            headEntry;
  logic              headValid;

  assign pop = instr_valid && instr_ready;

  // Slots already promised after this cycle: stored words plus the one on
  // its way back from the ROM, minus the one decode takes now. Issuing only
  // below QDEPTH guarantees every returning word has a home.
  assign occupancy = {1'b0, count} + OCC_W'(inflight) - OCC_W'(pop);
  assign issue     = !redirect && (occupancy < OCC_W'(QDEPTH));
  assign push      = inflight && !redirect;
  assign pushEntry = '{instr: mem_q, pc: inflightPc};

  assign mem_addr    = fetchPc;
  assign fetch_pc    = fetchPc;
  assign instr       = headEntry.instr;
  assign instr_pc    = headEntry.pc;
  assign instr_valid = headValid;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      fetchPc    <= ADDR_W'(RESET_PC);
      inflightPc <= '0;
      inflight   <= 1'b0;
    end else if (redirect) begin
      // The word returning next cycle belongs to the old stream; drop it.
      fetchPc  <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflightPc <= fetchPc;
        fetchPc    <= fetchPc + 1'b1;
      end
    end
  end

  fetch_queue #(
    .T      (entry_t),
    .QDEPTH (QDEPTH)
  ) queue (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .pushData  (pushEntry),
    .pop       (pop && !redirect),
    .headData  (headEntry),
    .headValid (headValid),
    .count     (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 1'b1;
      if (instr_valid && !instr_ready && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
    end
  end
`else
  // Without the counters the handshake needs no extra state.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [11:0] mem_addr;
  logic [15:0] mem_q;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic [11:0] fetch_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  logic [15:0] rom [0:4095];
  int checks = 0;
  int errors = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  // Synchronous ROM: address sampled on the edge, data valid the next cycle.
  always @(posedge CLOCK_50) mem_q <= rom[mem_addr];

  instr_fetch_unit dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_q       (mem_q),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_pc    (fetch_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expectHead(input string tag, input logic [11:0] pc, input logic [15:0] ins);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_pc"}, {20'd0, instr_pc}, {20'd0, pc});
    check({tag, "_instr"}, {16'd0, instr}, {16'd0, ins});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = {4'hC, 12'(i)};
    rom[0] = 16'h1123;
    rom[1] = 16'h2456;
    rom[2] = 16'h6A01;
    rom[3] = 16'h0000;

    reset       = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 12'h000;
    step(2);

    // Reset state
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'h0);
    check("rst_instr_pc", {20'd0, instr_pc}, 32'h0);
    check("rst_fetch_pc", {20'd0, fetch_pc}, 32'h0);
    check("rst_mem_addr", {20'd0, mem_addr}, 32'h0);

    // Scenario 1: release and stream with ready held high
    reset = 1'b1;
    step(1);
    check("s1_e1_valid", {31'd0, instr_valid}, 32'd0);
    check("s1_e1_fetch_pc", {20'd0, fetch_pc}, 32'h1);
    step(1); expectHead("s1_w0", 12'h000, 16'h1123);
    step(1); expectHead("s1_w1", 12'h001, 16'h2456);
    step(1); expectHead("s1_w2", 12'h002, 16'h6A01);
    step(1); expectHead("s1_w3", 12'h003, 16'h0000);

    // Scenario 2: decode stalls for 5 cycles after the first valid word
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    instr_ready = 1'b0;
    step(2);
    expectHead("s2_first", 12'h000, 16'h1123);
    check("s2_first_fetch_pc", {20'd0, fetch_pc}, 32'h2);
    for (int k = 0; k < 4; k++) begin
      step(1);
      expectHead("s2_hold", 12'h000, 16'h1123);
      check("s2_hold_fetch_pc", {20'd0, fetch_pc}, 32'h2);
    end
    instr_ready = 1'b1;
    step(1); expectHead("s2_w1", 12'h001, 16'h2456);
    step(1); expectHead("s2_w2", 12'h002, 16'h6A01);
    step(1); expectHead("s2_w3", 12'h003, 16'h0000);
    step(1); expectHead("s2_w4", 12'h004, 16'hC004);

    // Scenario 3: redirect with a word stored and another in flight
    redirect    = 1'b1;
    redirect_pc = 12'h0A0;
    step(1);
    redirect = 1'b0;
    check("s3_r1_valid", {31'd0, instr_valid}, 32'd0);
    check("s3_r1_fetch_pc", {20'd0, fetch_pc}, 32'h0A0);
    step(1);
    check("s3_r2_valid", {31'd0, instr_valid}, 32'd0);
    check("s3_r2_fetch_pc", {20'd0, fetch_pc}, 32'h0A1);
    step(1); expectHead("s3_w0", 12'h0A0, 16'hC0A0);
    step(1); expectHead("s3_w1", 12'h0A1, 16'hC0A1);

    // Scenario 4: PC wraps across the top of the address space
    redirect    = 1'b1;
    redirect_pc = 12'hFFE;
    step(1);
    redirect = 1'b0;
    check("s4_r1_valid", {31'd0, instr_valid}, 32'd0);
    step(1);
    check("s4_r2_valid", {31'd0, instr_valid}, 32'd0);
    step(1);
    expectHead("s4_wFFE", 12'hFFE, 16'hCFFE);
    check("s4_wrap_fetch_pc", {20'd0, fetch_pc}, 32'h000);
    step(1); expectHead("s4_wFFF", 12'hFFF, 16'hCFFF);
    step(1); expectHead("s4_w000", 12'h000, 16'h1123);
    step(1); expectHead("s4_w001", 12'h001, 16'h2456);

    // Back-to-back redirects: the later target wins
    redirect    = 1'b1;
    redirect_pc = 12'h100;
    step(1);
    redirect_pc = 12'h200;
    step(1);
    redirect = 1'b0;
    check("bb_valid", {31'd0, instr_valid}, 32'd0);
    check("bb_fetch_pc", {20'd0, fetch_pc}, 32'h200);
    step(2);
    expectHead("bb_w200", 12'h200, 16'hC200);

    // Scenario 5: asynchronous reset mid-stream, then identical restart
    #2;
    reset = 1'b0;
    #1;
    check("s5_async_valid", {31'd0, instr_valid}, 32'd0);
    check("s5_async_fetch_pc", {20'd0, fetch_pc}, 32'h0);
    check("s5_async_instr", {16'd0, instr}, 32'h0);
    step(1);
    reset = 1'b1;
    step(1);
    check("s5_e1_valid", {31'd0, instr_valid}, 32'd0);
    check("s5_e1_fetch_pc", {20'd0, fetch_pc}, 32'h1);
    step(1); expectHead("s5_w0", 12'h000, 16'h1123);
    step(1); expectHead("s5_w1", 12'h001, 16'h2456);
    step(1); expectHead("s5_w2", 12'h002, 16'h6A01);
    step(1); expectHead("s5_w3", 12'h003, 16'h0000);

`ifdef FETCH_PERF_EN
    // Scenario 6: 10 pops followed by 3 stalled cycles
    reset = 1'b0;
    step(1);
    check("s6_rst_fetched", perf_fetched, 32'd0);
    check("s6_rst_stall", perf_stall, 32'd0);
    reset = 1'b1;
    instr_ready = 1'b1;
    step(12);
    instr_ready = 1'b0;
    step(3);
    check("s6_fetched", perf_fetched, 32'd10);
    check("s6_stall", perf_stall, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
